disp_cmd_writer: RTL and testbench

DISP_CMD_WRITER -- requirements
Module: disp_cmd_writer

---
 rtl/disp_cmd_writer_pkg.sv | 42 ++++
 rtl/disp_cmd_writer_fifo_wr_port.sv | 59 +++++
 rtl/disp_cmd_writer.sv | 114 +++++++++++
 tb/tb_disp_cmd_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_cmd_writer_pkg.sv
// Shared command definitions for the display command path. The display-side
// command processor decodes the same opcodes and payload lengths.
package disp_cmd_writer_pkg;

    localparam int FONT_BYTES_DEF   = 4096;
    localparam int CHDATA_BYTES_DEF = 512;
    localparam int IDX_W            = 13;

    localparam logic [7:0] OP_LOAD_FONT   = 8'h80;
    localparam logic [7:0] OP_PIXDATA     = 8'h81;
    localparam logic [7:0] OP_LOAD_CHDATA = 8'h82;

    typedef enum logic [1:0] {
        CMD_PIXDATA     = 2'b00,
        CMD_LOAD_FONT   = 2'b01,
        CMD_LOAD_CHDATA = 2'b10,
        CMD_RESERVED    = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        P_IDLE,
        P_WAIT_ROOM,
        P_SETUP,
        P_STROBE,
        P_RECOVER
    } port_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FINISH
    } seq_state_e;

    function automatic logic [7:0] opcode_of(cmd_e cmd);
        case (cmd)
            CMD_LOAD_FONT:   return OP_LOAD_FONT;
            CMD_LOAD_CHDATA: return OP_LOAD_CHDATA;
            default:         return OP_PIXDATA;
        endcase
    endfunction

endpackage

// File: rtl/disp_cmd_writer_fifo_wr_port.sv
// Single-byte FIFO write port: waits for room, sets up data, pulses the
// active-low strobe for one cycle, then recovers for two cycles.
module fifo_wr_port
    import disp_cmd_writer_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       nff,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ack,
    output logic       recover_end,
    output logic [7:0] disp_cmd_out,
    output logic       disp_cmd_wr
);

    port_state_e state, state_next;
    logic        rec_cnt;
    logic [7:0]  out_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= P_IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            P_IDLE:      if (byte_valid) state_next = P_WAIT_ROOM;
            P_WAIT_ROOM: if (nff) state_next = P_SETUP;
            P_SETUP:     state_next = P_STROBE;
            P_STROBE:    state_next = P_RECOVER;
            P_RECOVER:   if (rec_cnt) state_next = byte_valid ? P_WAIT_ROOM : P_IDLE;
            default:     state_next = P_IDLE;
        endcase
    end

    // Data is captured on the way into SETUP and held through STROBE and RECOVER.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rec_cnt <= 1'b0;
            out_q   <= 8'h00;
        end else begin
            rec_cnt <= (state == P_RECOVER) && !rec_cnt;
            if (state == P_WAIT_ROOM && nff) out_q <= byte_in;
        end
    end

    always_comb begin
        disp_cmd_wr  = (state != P_STROBE);
        byte_ack     = (state == P_STROBE);
        recover_end  = (state == P_RECOVER) && rec_cnt;
        disp_cmd_out = out_q;
    end

endmodule

// File: rtl/disp_cmd_writer.sv
// Command sequencer: sends opcode then payload bytes through fifo_wr_port,
// reading font/character payloads from a synchronous source memory.
module disp_cmd_writer
    import disp_cmd_writer_pkg::*;
#(
    parameter int FONT_BYTES   = FONT_BYTES_DEF,
    parameter int CHDATA_BYTES = CHDATA_BYTES_DEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [1:0]  cmd_sel,
    input  logic [7:0]  pix_byte,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [7:0]  disp_cmd_out,
    output logic        disp_cmd_wr,
    input  logic        nff_in,
    output logic        busy,
    output logic        done
);

    seq_state_e       state, state_next;
    cmd_e             cmd_q;
    logic [7:0]       pix_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] last_idx_sel;
    logic             op_pending;
    logic             payload_done;
    logic             nff;
    logic             accept;
    logic             byte_valid;
    logic             byte_ack;
    logic             recover_end;
    logic [7:0]       cur_byte;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) nff <= 1'b0;
        else       nff <= nff_in;
    end

    assign accept = (state == S_IDLE) && start && (cmd_e'(cmd_sel) != CMD_RESERVED);

    always_comb begin
        case (cmd_e'(cmd_sel))
            CMD_LOAD_FONT:   last_idx_sel = IDX_W'(FONT_BYTES - 1);
            CMD_LOAD_CHDATA: last_idx_sel = IDX_W'(CHDATA_BYTES - 1);
            default:         last_idx_sel = '0;
        endcase
    end

    // The index stops at the last payload byte instead of wrapping, so
    // src_addr is left pointing at the final address after a transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_q        <= CMD_PIXDATA;
            pix_q        <= 8'h00;
            idx          <= '0;
            last_idx     <= '0;
            op_pending   <= 1'b0;
            payload_done <= 1'b0;
        end else if (accept) begin
            cmd_q        <= cmd_e'(cmd_sel);
            pix_q        <= pix_byte;
            idx          <= '0;
            last_idx     <= last_idx_sel;
            op_pending   <= 1'b1;
            payload_done <= 1'b0;
        end else if (byte_ack) begin
            if (op_pending)           op_pending   <= 1'b0;
            else if (idx == last_idx) payload_done <= 1'b1;
            else                      idx          <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_BUSY;
            S_BUSY:   if (payload_done && recover_end) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == S_BUSY);
        done       = (state == S_FINISH);
        byte_valid = (state == S_BUSY) && !payload_done;
        src_addr   = idx[11:0];
        if (op_pending)                cur_byte = opcode_of(cmd_q);
        else if (cmd_q == CMD_PIXDATA) cur_byte = pix_q;
        else                           cur_byte = src_data;
    end

    fifo_wr_port u_port (
        .clk          (clk),
        .nrst         (nrst),
        .nff          (nff),
        .byte_valid   (byte_valid),
        .byte_in      (cur_byte),
        .byte_ack     (byte_ack),
        .recover_end  (recover_end),
        .disp_cmd_out (disp_cmd_out),
        .disp_cmd_wr  (disp_cmd_wr)
    );

endmodule

// File: tb/tb_disp_cmd_writer.sv
// Directed bench for disp_cmd_writer: checks strobe contents, spacing,
// flow control, ignored requests and reset behaviour.
module tb_disp_cmd_writer;
    import disp_cmd_writer_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd_sel = 2'b00;
    logic [7:0]  pix_byte = 8'h00;
    logic [11:0] src_addr;
    logic [7:0]  src_data = 8'h00;
    logic [7:0]  disp_cmd_out;
    logic        disp_cmd_wr;
    logic        nff_in = 1'b1;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] strb_q[$];
    int strb_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;

    always #5 clk = ~clk;

    disp_cmd_writer dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .cmd_sel      (cmd_sel),
        .pix_byte     (pix_byte),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .disp_cmd_out (disp_cmd_out),
        .disp_cmd_wr  (disp_cmd_wr),
        .nff_in       (nff_in),
        .busy         (busy),
        .done         (done)
    );

    // Source memory model: one-cycle read latency, contents = addr[7:0].
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        src_data <= src_addr[7:0];
    end

    always @(negedge clk) begin
        if (!disp_cmd_wr) begin
            strb_q.push_back(disp_cmd_out);
            strb_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        cmd_sel  = c;
        pix_byte = p;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        pix_byte = 8'hFF;
    endtask

    task automatic wait_done(input int prev, input int budget, input string tag);
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(done_cnt != prev), 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int n = 0;
        while (strb_q.size() < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(strb_q.size() >= target), 32'd1);
    endtask

    task automatic clear_log();
        strb_q.delete();
        strb_cyc.delete();
    endtask

    // Counts strobes whose byte differs from opcode-then-addr[7:0] pattern.
    function automatic int stream_errors(input logic [7:0] op);
        int errs = 0;
        logic [7:0] exp_b;
        foreach (strb_q[i]) begin
            exp_b = (i == 0) ? op : 8'((i - 1) % 256);
            if (strb_q[i] !== exp_b) errs++;
        end
        return errs;
    endfunction

    function automatic int spacing_errors();
        int errs = 0;
        for (int i = 1; i < strb_cyc.size(); i++)
            if (strb_cyc[i] - strb_cyc[i-1] != 5) errs++;
        return errs;
    endfunction

    initial begin
        int prev;
        int w;

        // Reset state
        #2;
        check("rst_wr", 32'(disp_cmd_wr), 32'd1);
        check("rst_out", 32'(disp_cmd_out), 32'h00);
        check("rst_addr", 32'(src_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        // PIXDATA 0xA5
        clear_log();
        prev = done_cnt;
        pulse_start(2'b00, 8'hA5);
        check("pix_busy_after_start", 32'(busy), 32'd1);
        wait_done(prev, 200, "pix_done_seen");
        check("pix_count", 32'(strb_q.size()), 32'd2);
        if (strb_q.size() == 2) begin
            check("pix_byte0", 32'(strb_q[0]), 32'h81);
            check("pix_byte1", 32'(strb_q[1]), 32'hA5);
            check("pix_spacing", 32'(strb_cyc[1] - strb_cyc[0]), 32'd5);
            check("pix_done_lat", 32'(done_cyc - strb_cyc[1]), 32'd3);
        end
        check("pix_done_busy", 32'(done_busy), 32'd0);
        repeat (5) @(negedge clk);
        check("pix_one_done", 32'(done_cnt - prev), 32'd1);

        // LOAD_FONT, full 4096-byte payload
        clear_log();
        prev = done_cnt;
        pulse_start(2'b01, 8'h00);
        wait_done(prev, 25000, "font_done_seen");
        check("font_count", 32'(strb_q.size()), 32'd4097);
        check("font_data_errs", 32'(stream_errors(8'h80)), 32'd0);
        check("font_spacing_errs", 32'(spacing_errors()), 32'd0);
        check("font_last_addr", 32'(src_addr), 32'd4095);
        repeat (10) @(negedge clk);
        check("font_one_done", 32'(done_cnt - prev), 32'd1);

        // LOAD_CHDATA with a 20-cycle full stall after payload byte 100
        clear_log();
        prev = done_cnt;
        pulse_start(2'b10, 8'h00);
        wait_strobes(102, 2000, "chd_reach_byte100");
        nff_in = 1'b0;
        w = strb_q.size();
        repeat (20) @(negedge clk);
        #1;
        check("chd_no_strobe_full", 32'(strb_q.size()), 32'(w));
        nff_in = 1'b1;
        wait_done(prev, 5000, "chd_done_seen");
        check("chd_count", 32'(strb_q.size()), 32'd513);
        check("chd_data_errs", 32'(stream_errors(8'h82)), 32'd0);
        repeat (10) @(negedge clk);
        check("chd_one_done", 32'(done_cnt - prev), 32'd1);

        // start while busy is ignored; pix_byte latched at accept
        clear_log();
        prev = done_cnt;
        pulse_start(2'b00, 8'h3C);
        repeat (3) @(negedge clk);
        cmd_sel  = 2'b01;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(prev, 200, "ign_done_seen");
        repeat (40) @(negedge clk);
        check("ign_count", 32'(strb_q.size()), 32'd2);
        if (strb_q.size() >= 2) check("ign_byte1", 32'(strb_q[1]), 32'h3C);
        check("ign_one_done", 32'(done_cnt - prev), 32'd1);

        // Reserved command in IDLE does nothing
        clear_log();
        prev = done_cnt;
        pulse_start(2'b11, 8'h11);
        check("rsv_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("rsv_no_strobe", 32'(strb_q.size()), 32'd0);
        check("rsv_no_done", 32'(done_cnt - prev), 32'd0);

        // Reset during the strobe of LOAD_FONT payload byte 50
        clear_log();
        pulse_start(2'b01, 8'h00);
        wait_strobes(52, 1000, "rst_reach_byte50");
        check("rst_in_strobe", 32'(disp_cmd_wr), 32'd0);
        nrst = 1'b0;
        #1;
        check("rst_mid_wr", 32'(disp_cmd_wr), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_out", 32'(disp_cmd_out), 32'h00);
        check("rst_mid_addr", 32'(src_addr), 32'd0);
        prev = done_cnt;
        clear_log();
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_strobe", 32'(strb_q.size()), 32'd0);
        check("rst_no_done", 32'(done_cnt - prev), 32'd0);

        // PIXDATA after reset
        clear_log();
        prev = done_cnt;
        pulse_start(2'b00, 8'h5A);
        wait_done(prev, 200, "post_done_seen");
        check("post_count", 32'(strb_q.size()), 32'd2);
        if (strb_q.size() == 2) begin
            check("post_byte0", 32'(strb_q[0]), 32'h81);
            check("post_byte1", 32'(strb_q[1]), 32'h5A);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
